// File: rtl/debouncer_bank.sv
`default_nettype none
// ------------------------------------------------------------------------
// debouncer_bank : per-channel sync + stability debounce, rise/fall pulses
//                  and long-press / auto-repeat hold pulses.  Rev 1.0
// ------------------------------------------------------------------------
module debouncer_bank #(
    parameter int CHANNELS    = 4,
    parameter int COUNT_WIDTH = 8,
    parameter int COUNT_MAX   = 255,
    parameter int HOLD_WIDTH  = 16,
    parameter int HOLD_MAX    = 49999,
    parameter int REPEAT_MAX  = 9999
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] din,
    input  logic                repeat_en,
    output logic [CHANNELS-1:0] dout,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] hold
);

    localparam logic [COUNT_WIDTH-1:0] CNT_TERM  = COUNT_WIDTH'(COUNT_MAX);
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE   = COUNT_WIDTH'(1);
    localparam logic [HOLD_WIDTH-1:0]  HOLD_TERM = HOLD_WIDTH'(HOLD_MAX);
    localparam logic [HOLD_WIDTH-1:0]  REP_TERM  = HOLD_WIDTH'(REPEAT_MAX);
    localparam logic [HOLD_WIDTH-1:0]  HCNT_ONE  = HOLD_WIDTH'(1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_PRESS  = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic                   sync1_q, sync2_q;
        logic                   cand_q, cand_d;
        logic                   dout_q, dout_d;
        logic                   rise_q, rise_d;
        logic                   fall_q, fall_d;
        logic                   hold_q, hold_d;
        logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
        logic [1:0]             state_q, state_d;
        logic [HOLD_WIDTH-1:0]  hcnt_q, hcnt_d;

        // A new candidate level restarts the count; dout follows once it has held.
        always_comb begin
            cand_d = cand_q;
            cnt_d  = cnt_q;
            dout_d = dout_q;
            if (sync2_q != cand_q) begin
                cand_d = sync2_q;
                cnt_d  = '0;
            end else if (cnt_q == CNT_TERM) begin
                dout_d = cand_q;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end

        assign rise_d = dout_d & ~dout_q;
        assign fall_d = ~dout_d & dout_q;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                sync1_q <= 1'b0;
                sync2_q <= 1'b0;
                cand_q  <= 1'b0;
                cnt_q   <= '0;
                dout_q  <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                sync1_q <= din[i];
                sync2_q <= sync1_q;
                cand_q  <= cand_d;
                cnt_q   <= cnt_d;
                dout_q  <= dout_d;
                rise_q  <= rise_d;
                fall_q  <= fall_d;
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                state_q <= ST_IDLE;
                hcnt_q  <= '0;
                hold_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                hcnt_q  <= hcnt_d;
                hold_q  <= hold_d;
            end
        end

        // A release overrides whatever the hold timer was doing.
        always_comb begin
            state_d = state_q;
            hcnt_d  = hcnt_q;
            if (fall_d) begin
                state_d = ST_IDLE;
                hcnt_d  = '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (rise_d) begin
                            state_d = ST_PRESS;
                            hcnt_d  = '0;
                        end
                    end
                    ST_PRESS: begin
                        if (hcnt_q == HOLD_TERM) begin
                            hcnt_d  = '0;
                            state_d = repeat_en ? ST_REPEAT : ST_DONE;
                        end else begin
                            hcnt_d = hcnt_q + HCNT_ONE;
                        end
                    end
                    ST_REPEAT: begin
                        if (!repeat_en) begin
                            state_d = ST_DONE;
                            hcnt_d  = '0;
                        end else if (hcnt_q == REP_TERM) begin
                            hcnt_d = '0;
                        end else begin
                            hcnt_d = hcnt_q + HCNT_ONE;
                        end
                    end
                    default: begin
                        state_d = state_q;
                    end
                endcase
            end
        end

        always_comb begin
            hold_d = 1'b0;
            if (!fall_d) begin
                case (state_q)
                    ST_PRESS:  hold_d = (hcnt_q == HOLD_TERM);
                    ST_REPEAT: hold_d = repeat_en && (hcnt_q == REP_TERM);
                    default:   hold_d = 1'b0;
                endcase
            end
        end

        assign dout[i] = dout_q;
        assign rise[i] = rise_q;
        assign fall[i] = fall_q;
        assign hold[i] = hold_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_debouncer_bank.sv
`default_nettype none
// Directed stimulus with a run-length / elapsed-time reference model compared every cycle.
module tb_debouncer_bank;

    localparam int CH = 4;
    localparam int CM = 3;
    localparam int HM = 9;
    localparam int RM = 4;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          repeat_en = 1'b0;
    logic [CH-1:0] din       = '0;
    logic [CH-1:0] dout, rise, fall, hold;

    debouncer_bank #(
        .CHANNELS   (CH),
        .COUNT_WIDTH(8),
        .COUNT_MAX  (CM),
        .HOLD_WIDTH (16),
        .HOLD_MAX   (HM),
        .REPEAT_MAX (RM)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .repeat_en(repeat_en),
        .dout     (dout),
        .rise     (rise),
        .fall     (fall),
        .hold     (hold)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    // Reference model state
    logic [CH-1:0] m_past0 = '0, m_past1 = '0, m_prev = '0, m_lvl = '0;
    logic [CH-1:0] m_armed = '0, m_rep = '0;
    int            m_run [CH];
    int            m_age [CH];
    logic [CH-1:0] exp_dout = '0, exp_rise = '0, exp_fall = '0, exp_hold = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_n, act, exp);
        end
    endtask

    // dout takes a level once the synchronized input has shown it for CM+2 consecutive edges;
    // hold pulses are timed from the rise edge by elapsed-cycle arithmetic.
    task automatic model_step();
        logic s, nl, r, f, h;
        edge_n++;
        if (!rst_n) begin
            m_past0 = '0; m_past1 = '0; m_prev = '0; m_lvl = '0;
            m_armed = '0; m_rep = '0;
            for (int i = 0; i < CH; i++) begin
                m_run[i] = 1;
                m_age[i] = 0;
            end
            exp_dout = '0; exp_rise = '0; exp_fall = '0; exp_hold = '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                s = m_past1[i];
                if (s == m_prev[i]) m_run[i]++;
                else m_run[i] = 1;
                m_prev[i] = s;
                nl = (m_run[i] >= CM + 2) ? s : m_lvl[i];
                r  = nl & ~m_lvl[i];
                f  = ~nl & m_lvl[i];
                m_lvl[i] = nl;
                h = 1'b0;
                if (f) begin
                    m_armed[i] = 1'b0;
                end else if (r) begin
                    m_armed[i] = 1'b1;
                    m_age[i]   = 0;
                    m_rep[i]   = 1'b0;
                end else if (m_armed[i]) begin
                    m_age[i]++;
                    if (m_age[i] == HM + 1) begin
                        h = 1'b1;
                        m_rep[i] = repeat_en;
                    end else if (m_age[i] > HM + 1) begin
                        if (!repeat_en) m_rep[i] = 1'b0;
                        else if (m_rep[i] && ((m_age[i] - (HM + 1)) % (RM + 1)) == 0) h = 1'b1;
                    end
                end
                exp_dout[i] = nl;
                exp_rise[i] = r;
                exp_fall[i] = f;
                exp_hold[i] = h;
            end
            m_past1 = m_past0;
            m_past0 = din;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (edge_n > 0) begin
            check("dout", 32'(dout), 32'(exp_dout));
            check("rise", 32'(rise), 32'(exp_rise));
            check("fall", 32'(fall), 32'(exp_fall));
            check("hold", 32'(hold), 32'(exp_hold));
        end
    end

    // sel: 0 rise, 1 fall, 2 hold. Returns the edge index of the first pulse, or -1.
    task automatic wait_ev(input int sel, input int ch, input int budget, output int at);
        logic b;
        at = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            b = (sel == 0) ? rise[ch] : (sel == 1) ? fall[ch] : hold[ch];
            if (b) begin
                at = edge_n;
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int at, r, n, cnt;

        // 1. Reset with all inputs high, then release
        din = 4'hF;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("reset_outs", 32'({dout, rise, fall, hold}), 32'h0);
        end
        rst_n = 1'b1;
        n = edge_n;
        wait_ev(0, 0, 20, r);
        check("t1_rise_edge", r, n + 7);
        check("t1_rise_vec", 32'(rise), 32'hF);
        check("t1_dout_vec", 32'(dout), 32'hF);
        @(negedge clk);
        check("t1_rise_once", 32'(rise), 32'h0);
        wait_ev(2, 0, 20, at);
        check("t1_hold_edge", at, r + 10);
        din = 4'h0;
        n = edge_n;
        wait_ev(1, 0, 20, at);
        check("t1_fall_edge", at, n + 7);
        repeat (5) @(negedge clk);

        // 2a. Bouncing input on channel 0
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            din[0] = ~din[0];
            repeat (2) begin
                @(negedge clk);
                cnt += int'(rise[0]);
            end
        end
        din[0] = 1'b1;
        n = edge_n;
        check("t2_bounce_rises", cnt, 0);
        wait_ev(0, 0, 20, at);
        check("t2_settle_rise_edge", at, n + 7);
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            cnt += int'(rise[0]);
        end
        check("t2_single_rise", cnt, 0);

        // 2b. Short pulse on channel 1
        din[1] = 1'b1;
        repeat (3) @(negedge clk);
        din[1] = 1'b0;
        cnt = 0;
        repeat (15) begin
            @(negedge clk);
            cnt += int'(dout[1] | rise[1] | fall[1]);
        end
        check("t2_glitch_reject", cnt, 0);

        // 3. Long press without repeat on channel 2
        repeat_en = 1'b0;
        din[2] = 1'b1;
        n = edge_n;
        wait_ev(0, 2, 20, r);
        check("t3_rise_edge", r, n + 7);
        wait_ev(2, 2, 20, at);
        check("t3_hold_edge", at, r + 10);
        cnt = 0;
        repeat (100) begin
            @(negedge clk);
            cnt += int'(hold[2]);
        end
        check("t3_no_more_hold", cnt, 0);
        din[2] = 1'b0;
        n = edge_n;
        wait_ev(1, 2, 20, at);
        check("t3_fall_edge", at, n + 7);
        check("t3_hold_on_fall", 32'(hold[2]), 32'h0);

        // 4. Auto-repeat on channel 3
        repeat_en = 1'b1;
        din[3] = 1'b1;
        n = edge_n;
        wait_ev(0, 3, 20, r);
        check("t4_rise_edge", r, n + 7);
        wait_ev(2, 3, 20, at);
        check("t4_hold1", at, r + 10);
        wait_ev(2, 3, 20, at);
        check("t4_hold2", at, r + 15);
        wait_ev(2, 3, 20, at);
        check("t4_hold3", at, r + 20);
        repeat_en = 1'b0;
        cnt = 0;
        repeat (30) begin
            @(negedge clk);
            cnt += int'(hold[3]);
        end
        repeat_en = 1'b1;
        repeat (20) begin
            @(negedge clk);
            cnt += int'(hold[3]);
        end
        check("t4_done_sticky", cnt, 0);
        din[3] = 1'b0;
        repeat (12) @(negedge clk);
        din[3] = 1'b1;
        n = edge_n;
        wait_ev(0, 3, 20, r);
        check("t4b_rise_edge", r, n + 7);
        wait_ev(2, 3, 20, at);
        check("t4b_hold1", at, r + 10);
        while (edge_n < r + 13) @(negedge clk);
        din[3] = 1'b0;
        wait_ev(2, 3, 20, at);
        check("t4b_hold2", at, r + 15);
        while (edge_n < r + 20) @(negedge clk);
        check("t4b_fall_at_term", 32'(fall[3]), 32'h1);
        check("t4b_no_hold_at_term", 32'(hold[3]), 32'h0);

        // 5. Simultaneous rise/fall, then reset during PRESS
        din[0] = 1'b0;
        din[3] = 1'b1;
        repeat (12) @(negedge clk);
        din[0] = 1'b1;
        din[3] = 1'b0;
        n = edge_n;
        wait_ev(0, 0, 20, at);
        check("t5_simul_edge", at, n + 7);
        check("t5_simul_rise", 32'(rise), 32'h1);
        check("t5_simul_fall", 32'(fall), 32'h8);
        repeat (5) @(negedge clk);
        din[2] = 1'b1;
        n = edge_n;
        wait_ev(0, 2, 20, r);
        check("t5_press_rise", r, n + 7);
        while (edge_n < r + 4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("t5_reset_outs", 32'({dout, rise, fall, hold}), 32'h0);
        rst_n = 1'b1;
        wait_ev(0, 2, 20, at);
        check("t5_rerise_edge", at, r + 12);
        check("t5_rerise_vec", 32'(rise), 32'h5);
        r = at;
        wait_ev(2, 2, 20, at);
        check("t5_rehold_edge", at, r + 10);
        repeat (10) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
